// File: rtl/jelly_cpu_memenc_split_if.sv
// Request/beat bundle between the CPU memory stage, the store encoder and the data bus master.
// The bench/CPU side uses the master modport; the encoder uses the slave modport.
interface jelly_cpu_memenc_split_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [1:0]            s_size;
  logic                  s_valid;
  logic                  s_ready;

  logic [ADDR_WIDTH-1:0] m_addr;
  logic [SEL_WIDTH-1:0]  m_sel;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_last;
  logic                  m_misalign;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output s_addr, s_wdata, s_size, s_valid, m_ready,
    input  s_ready, m_addr, m_sel, m_wdata, m_last, m_misalign, m_valid
  );

  modport slave (
    input  s_addr, s_wdata, s_size, s_valid, m_ready,
    output s_ready, m_addr, m_sel, m_wdata, m_last, m_misalign, m_valid
  );
endinterface

// File: rtl/jelly_cpu_memenc_split.sv
// Store-side memory access encoder: positions store data onto bus lanes, splitting boundary-crossing
// accesses into two beats when JELLY_MEMENC_SPLIT_EN is defined (otherwise flags them with m_misalign).
module jelly_cpu_memenc_split #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic endian,
  jelly_cpu_memenc_split_if.slave bus
);
  localparam int OFS_W = $clog2(SEL_WIDTH);

  function automatic int eff_bytes(input logic [1:0] size);
    if (DATA_WIDTH == 32 && size == 2'd3) return 4;
    return 1 << size;
  endfunction

  // Lane mask over a double-width window; upper half belongs to the second beat.
  function automatic logic [2*SEL_WIDTH-1:0] enc_sel(input int ofs, input int nb);
    logic [2*SEL_WIDTH-1:0] sel;
    sel = '0;
    for (int k = 0; k < SEL_WIDTH; k++)
      if (k < nb) sel[ofs+k] = 1'b1;
    return sel;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] enc_data(input logic [DATA_WIDTH-1:0] wd, input int ofs,
                                                     input int nb, input logic be, input logic beat);
    logic [DATA_WIDTH-1:0] d;
    int lane;
    d = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      if (k < nb) begin
        lane = be ? (ofs + nb - 1 - k) : (ofs + k);
        if ((lane >= SEL_WIDTH) == beat)
          d[8*(lane % SEL_WIDTH) +: 8] = wd[8*k +: 8];
      end
    end
    return d;
  endfunction

  int                     ofs_p0;
  int                     nb_p0;
  logic [2*SEL_WIDTH-1:0] sel2_p0;
  logic                   cross_p0;
  logic [ADDR_WIDTH-1:0]  addr0_p0;
  logic [SEL_WIDTH-1:0]   sel0_p0;
  logic [DATA_WIDTH-1:0]  wdata0_p0;

  logic [ADDR_WIDTH-1:0]  addr_p1;
  logic [SEL_WIDTH-1:0]   sel_p1;
  logic [DATA_WIDTH-1:0]  wdata_p1;
  logic                   last_p1;
  logic                   vld_p1;

  logic                   drain_ok;
  logic                   ready;
  logic                   load_req;

  // p0: combinational encode of the incoming request
  always_comb begin
    ofs_p0    = int'(bus.s_addr[OFS_W-1:0]);
    nb_p0     = eff_bytes(bus.s_size);
    sel2_p0   = enc_sel(ofs_p0, nb_p0);
    cross_p0  = |sel2_p0[2*SEL_WIDTH-1:SEL_WIDTH];
    addr0_p0  = {bus.s_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
    sel0_p0   = sel2_p0[SEL_WIDTH-1:0];
    wdata0_p0 = enc_data(bus.s_wdata, ofs_p0, nb_p0, endian, 1'b0);
  end

  assign drain_ok    = !vld_p1 || bus.m_ready;
  assign bus.s_ready = ready;

`ifdef JELLY_MEMENC_SPLIT_EN
  typedef enum logic {ST_IDLE, ST_SECOND} state_t;

  state_t                state;
  state_t                state_nx;
  logic                  load_hold;
  logic [ADDR_WIDTH-1:0] addr1_p0;
  logic [SEL_WIDTH-1:0]  sel1_p0;
  logic [DATA_WIDTH-1:0] wdata1_p0;
  logic [ADDR_WIDTH-1:0] addr_h;
  logic [SEL_WIDTH-1:0]  sel_h;
  logic [DATA_WIDTH-1:0] wdata_h;

  always_comb begin
    addr1_p0  = addr0_p0 + ADDR_WIDTH'(SEL_WIDTH);
    sel1_p0   = sel2_p0[2*SEL_WIDTH-1:SEL_WIDTH];
    wdata1_p0 = enc_data(bus.s_wdata, ofs_p0, nb_p0, endian, 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    load_req  = 1'b0;
    load_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = drain_ok;
        if (bus.s_valid && drain_ok) begin
          load_req = 1'b1;
          if (cross_p0) state_nx = ST_SECOND;
        end
      end
      ST_SECOND: begin
        if (drain_ok) begin
          load_hold = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // hold: second beat of a crossing request, validity tracked by the FSM
  always_ff @(posedge clk) begin
    if (load_req && cross_p0) begin
      addr_h  <= addr1_p0;
      sel_h   <= sel1_p0;
      wdata_h <= wdata1_p0;
    end
  end

  assign bus.m_misalign = 1'b0;
`else
  logic misalign_p1;

  assign ready          = drain_ok;
  assign load_req       = bus.s_valid && drain_ok;
  assign bus.m_misalign = misalign_p1;
`endif

  // p1: output beat register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_p1     <= '0;
      sel_p1      <= '0;
      wdata_p1    <= '0;
      last_p1     <= 1'b0;
      vld_p1      <= 1'b0;
`ifndef JELLY_MEMENC_SPLIT_EN
      misalign_p1 <= 1'b0;
`endif
    end else if (load_req) begin
      addr_p1  <= addr0_p0;
      sel_p1   <= sel0_p0;
      wdata_p1 <= wdata0_p0;
      vld_p1   <= 1'b1;
`ifdef JELLY_MEMENC_SPLIT_EN
      last_p1  <= !cross_p0;
`else
      last_p1     <= 1'b1;
      misalign_p1 <= cross_p0;
`endif
    end
`ifdef JELLY_MEMENC_SPLIT_EN
    else if (load_hold) begin
      addr_p1  <= addr_h;
      sel_p1   <= sel_h;
      wdata_p1 <= wdata_h;
      last_p1  <= 1'b1;
      vld_p1   <= 1'b1;
    end
`endif
    else if (vld_p1 && bus.m_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.m_addr  = addr_p1;
  assign bus.m_sel   = sel_p1;
  assign bus.m_wdata = wdata_p1;
  assign bus.m_last  = last_p1;
  assign bus.m_valid = vld_p1;
endmodule

// File: tb/tb_jelly_cpu_memenc_split.sv
// Directed bench for jelly_cpu_memenc_split: 32-bit and 64-bit instances, expectations follow
// whichever build (split enabled or not) is compiled.
module tb_jelly_cpu_memenc_split;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic endian  = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  jelly_cpu_memenc_split_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
  jelly_cpu_memenc_split_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

  jelly_cpu_memenc_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .endian(endian), .bus(b32.slave)
  );
  jelly_cpu_memenc_split #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u64 (
    .clk(clk), .reset_n(reset_n), .endian(endian), .bus(b64.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic be);
    b32.s_addr  = a;
    b32.s_wdata = d;
    b32.s_size  = sz;
    b32.s_valid = 1'b1;
    endian      = be;
  endtask

  task automatic beat32(input string tag, input logic [31:0] a, input logic [3:0] sel,
                        input logic [31:0] d, input logic last, input logic mis);
    check({tag, "_vld"},  64'(b32.m_valid),    64'h1);
    check({tag, "_addr"}, 64'(b32.m_addr),     64'(a));
    check({tag, "_sel"},  64'(b32.m_sel),      64'(sel));
    check({tag, "_data"}, 64'(b32.m_wdata),    64'(d));
    check({tag, "_last"}, 64'(b32.m_last),     64'(last));
    check({tag, "_mis"},  64'(b32.m_misalign), 64'(mis));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b32.s_addr = '0; b32.s_wdata = '0; b32.s_size = '0; b32.s_valid = 1'b0; b32.m_ready = 1'b1;
    b64.s_addr = '0; b64.s_wdata = '0; b64.s_size = '0; b64.s_valid = 1'b0; b64.m_ready = 1'b1;

    step(); step(); step();
    check("rst_vld",  64'(b32.m_valid), 64'h0);
    check("rst_sel",  64'(b32.m_sel),   64'h0);
    check("rst_data", 64'(b32.m_wdata), 64'h0);
    check("rst_addr", 64'(b32.m_addr),  64'h0);
    check("rst_last", 64'(b32.m_last),  64'h0);
    reset_n = 1'b1;
    step();
    check("rst_rdy", 64'(b32.s_ready), 64'h1);

    // LE byte at lane 3
    drive32(32'h1003, 32'hA5, 2'd0, 1'b0);
    step(); b32.s_valid = 1'b0;
    beat32("le_byte", 32'h1000, 4'b1000, 32'hA500_0000, 1'b1, 1'b0);
    step();
    check("le_byte_done", 64'(b32.m_valid), 64'h0);

    // BE half on lanes 2..3
    drive32(32'h2002, 32'h1234, 2'd1, 1'b1);
    step(); b32.s_valid = 1'b0;
    beat32("be_half", 32'h2000, 4'b1100, 32'h3412_0000, 1'b1, 1'b0);
    step();

    // LE word crossing at 0x3001
    drive32(32'h3001, 32'hDDCC_BBAA, 2'd2, 1'b0);
    step(); b32.s_valid = 1'b0;
`ifdef JELLY_MEMENC_SPLIT_EN
    beat32("cross_b0", 32'h3000, 4'b1110, 32'hCCBB_AA00, 1'b0, 1'b0);
    check("cross_rdy", 64'(b32.s_ready), 64'h0);
    step();
    beat32("cross_b1", 32'h3004, 4'b0001, 32'h0000_00DD, 1'b1, 1'b0);
`else
    beat32("cross_b0", 32'h3000, 4'b1110, 32'hCCBB_AA00, 1'b1, 1'b1);
`endif
    step();
    check("cross_done", 64'(b32.m_valid), 64'h0);

    // LE word at top of address space with a 3-cycle stall on beat 0
    b32.m_ready = 1'b0;
    drive32(32'hFFFF_FFFE, 32'h4433_2211, 2'd2, 1'b0);
    step(); b32.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef JELLY_MEMENC_SPLIT_EN
      beat32("wrap_stall", 32'hFFFF_FFFC, 4'b1100, 32'h2211_0000, 1'b0, 1'b0);
`else
      beat32("wrap_stall", 32'hFFFF_FFFC, 4'b1100, 32'h2211_0000, 1'b1, 1'b1);
`endif
      check("wrap_stall_rdy", 64'(b32.s_ready), 64'h0);
      step();
    end
    b32.m_ready = 1'b1;
    step();
`ifdef JELLY_MEMENC_SPLIT_EN
    beat32("wrap_b1", 32'h0000_0000, 4'b0011, 32'h0000_4433, 1'b1, 1'b0);
    step();
`endif
    check("wrap_done", 64'(b32.m_valid), 64'h0);

    // Back-to-back non-crossing: BE word, then size 3 treated as word
    drive32(32'h5000, 32'h1122_3344, 2'd2, 1'b1);
    check("b2b_rdy0", 64'(b32.s_ready), 64'h1);
    step();
    beat32("b2b_a", 32'h5000, 4'b1111, 32'h4433_2211, 1'b1, 1'b0);
    drive32(32'h6003, 32'hCAFE_BABE, 2'd3, 1'b0);
    check("b2b_rdy1", 64'(b32.s_ready), 64'h1);
    step(); b32.s_valid = 1'b0;
`ifdef JELLY_MEMENC_SPLIT_EN
    beat32("b2b_b", 32'h6000, 4'b1000, 32'hBE00_0000, 1'b0, 1'b0);
    step();
    beat32("b2b_b1", 32'h6004, 4'b0111, 32'h00CA_FEBA, 1'b1, 1'b0);
`else
    beat32("b2b_b", 32'h6000, 4'b1000, 32'hBE00_0000, 1'b1, 1'b1);
`endif
    step();
    check("b2b_done", 64'(b32.m_valid), 64'h0);

    // 64-bit BE dword crossing at 0x4004
    b64.s_addr = 32'h4004; b64.s_wdata = 64'h0102_0304_0506_0708; b64.s_size = 2'd3;
    b64.s_valid = 1'b1; endian = 1'b1;
    step(); b64.s_valid = 1'b0;
    check("d64_b0_addr", 64'(b64.m_addr),  64'h4000);
    check("d64_b0_sel",  64'(b64.m_sel),   64'hF0);
    check("d64_b0_data", b64.m_wdata,      64'h0403_0201_0000_0000);
`ifdef JELLY_MEMENC_SPLIT_EN
    check("d64_b0_last", 64'(b64.m_last),  64'h0);
    step();
    check("d64_b1_addr", 64'(b64.m_addr),  64'h4008);
    check("d64_b1_sel",  64'(b64.m_sel),   64'h0F);
    check("d64_b1_data", b64.m_wdata,      64'h0000_0000_0807_0605);
    check("d64_b1_last", 64'(b64.m_last),  64'h1);
`else
    check("d64_b0_last", 64'(b64.m_last),     64'h1);
    check("d64_b0_mis",  64'(b64.m_misalign), 64'h1);
`endif
    step();
    check("d64_done", 64'(b64.m_valid), 64'h0);

    // Reset in the middle of a stalled crossing request
    b32.m_ready = 1'b0;
    drive32(32'h3001, 32'hDDCC_BBAA, 2'd2, 1'b0);
    step(); b32.s_valid = 1'b0;
    check("mid_vld", 64'(b32.m_valid), 64'h1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_vld", 64'(b32.m_valid), 64'h0);
    check("mid_rst_sel", 64'(b32.m_sel),   64'h0);
    step();
    reset_n = 1'b1;
    b32.m_ready = 1'b1;
    step();
    check("mid_post0", 64'(b32.m_valid), 64'h0);
    step();
    check("mid_post1", 64'(b32.m_valid), 64'h0);
    check("mid_rdy",   64'(b32.s_ready), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jelly_cpu_memenc_split.md
# jelly_cpu_memenc_split

Pipelined, parametrised store-side memory access encoder for the Jelly CPU data bus. Takes a byte address, write data, access size and endian mode, and produces bus-aligned address, byte-lane select and lane-positioned write data. Accesses that cross a bus-word boundary are split into two bus beats. Sits between the CPU execute/memory stage and the data bus master, with valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 32 — bus data width; 32 or 64
- ADDR_WIDTH, 32 — byte address width
- SEL_WIDTH, DATA_WIDTH/8 — lanes per beat (derived; do not override)
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- endian  input  1  0 = little-endian, 1 = big-endian; sampled on accept
- s_addr  input  ADDR_WIDTH  byte address
- s_wdata  input  DATA_WIDTH  store data, right-justified
- s_size  input  2  0 byte, 1 half, 2 word, 3 dword; 3 is treated as 2 when DATA_WIDTH=32
- s_valid  input  1  request valid
- s_ready  output  1  request accepted when s_valid && s_ready
- m_addr  output  ADDR_WIDTH  beat address, low log2(SEL_WIDTH) bits zero
- m_sel  output  SEL_WIDTH  byte-lane enables
- m_wdata  output  DATA_WIDTH  lane-positioned data; disabled lanes are 0
- m_last  output  1  final beat of the request
- m_misalign  output  1  request crossed a boundary and was not split
- m_valid  output  1  beat valid
- m_ready  input  1  beat consumed when m_valid && m_ready

## Operation
- Lane i occupies m_wdata[8i+7:8i] and corresponds to byte offset i within the bus word.
- o = s_addr[log2(SEL_WIDTH)-1:0]; n = 1 << size (effective size).
- Little-endian: data byte k (k=0 is LSB) goes to lane o+k. Big-endian: data byte k goes to lane o+n-1-k.
- Crossing when o+n > SEL_WIDTH. Lanes at o+k >= SEL_WIDTH map to lane o+k-SEL_WIDTH of the second beat.
- Second-beat address = aligned address + SEL_WIDTH, modulo 2^ADDR_WIDTH (wrap-around).
- FSM states:
  - ST_IDLE: may accept.
  - ST_SECOND: second beat held in hold registers, waiting for the output stage.
- s_ready = (state==ST_IDLE) && (!m_valid || m_ready).
- On accept: output registers load beat 0 and m_valid←1.
  - Crossing: hold registers load beat 1, m_last←0, state←ST_SECOND.
  - Otherwise: m_last←1.
- In ST_SECOND, when !m_valid || m_ready: outputs load the hold registers, m_last←1, state←ST_IDLE.
- When m_valid && m_ready and nothing loads: m_valid←0.
- Outputs are stable while m_valid && !m_ready.

## Timing
- Reset: all of the following are 0: m_valid, m_last, m_misalign, m_sel, m_wdata, m_addr, state (ST_IDLE). s_ready = 1 after reset.
- Latency: beat 0 is valid the cycle after accept. Beat 1 follows the cycle after beat 0 is consumed (back-to-back if m_ready=1).
- Throughput: non-crossing requests 1 per cycle; crossing requests 2 cycles each.
- Accept and drain can happen in the same cycle; the new beat replaces the consumed one with no bubble.
- Reset asserted mid-request discards the pending second beat immediately; no partial beat is emitted after reset release.

## Configuration
- JELLY_MEMENC_SPLIT_EN defined: behaviour as above; m_misalign is always 0.
- JELLY_MEMENC_SPLIT_EN undefined:
  - ST_SECOND and the hold registers are removed.
  - A crossing request is issued as a single beat containing only the beat-0 lanes, with m_last=1 and m_misalign=1.
  - Non-crossing behaviour is identical.

## Test plan
All cases use DATA_WIDTH=32 unless stated.
- Reset: hold reset_n=0 → m_valid=0, m_sel=0, m_wdata=0, s_ready=1 after release.
- LE byte, addr 0x1003, data 0xA5 → next cycle: m_addr=0x1000, m_sel=1000b, m_wdata=0xA5000000, m_last=1.
- BE half, addr 0x2002, data 0x1234 → m_sel=1100b, m_wdata=0x34120000, m_last=1.
- LE word, addr 0x3001, data 0xDDCCBBAA, split enabled →
  - beat 0: m_addr=0x3000, m_sel=1110b, m_wdata=0xCCBBAA00, m_last=0; s_ready=0.
  - beat 1: m_addr=0x3004, m_sel=0001b, m_wdata=0x000000DD, m_last=1.
  - Same request without the macro: single beat m_sel=1110b, m_misalign=1.
- LE word at 0xFFFFFFFE → beat 1 has m_addr=0x00000000, m_sel=0011b. Hold m_ready=0 for 3 cycles during beat 0 → all outputs stable.
- DATA_WIDTH=64, BE dword, addr 0x4004, data 0x0102030405060708 →
  - beat 0: m_sel=0xF0, lanes 4..7 = 01,02,03,04.
  - beat 1: m_addr=0x4008, m_sel=0x0F, lanes 0..3 = 05,06,07,08.
